mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Initiator-side controller that drives `memory_block` on behalf of the processor datapath. It accepts one load or store request at a time through a valid/ready handshake and sequences the `memRead`/`memWrite`/`byteOperations`/`address`/`write_data` strobes for a fixed access window. For loads, it captures `read_data`, sign- or zero-extends byte loads, and returns the result as a single-cycle response. It sits between the load/store stage and the data memory.

## Interface
Parameters:
- `MEM_LATENCY`, default 1: number of cycles the memory strobes are held per access. Minimum 1.
- `ADDR_W`, default 18: width of the memory address.

Ports:
- `clk`  in  1  system clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  unit can accept a request.
- `req_write`  in  1  1 = store, 0 = load.
- `req_byte`  in  1  1 = byte access, 0 = word access.
- `req_signed`  in  1  byte load only: 1 = sign-extend, 0 = zero-extend.
- `req_addr`  in  ADDR_W  byte address.
- `req_wdata`  in  32  store data.
- `rsp_valid`  out  1  one-cycle response pulse.
- `rsp_data`  out  32  load result; 0 for stores.
- `rsp_error`  out  1  misaligned-access flag; valid with `rsp_valid`.
- `address`  out  ADDR_W  to memory.
- `write_data`  out  32  to memory.
- `byteOperations`  out  1  to memory.
- `memRead`  out  1  to memory.
- `memWrite`  out  1  to memory.
- `read_data`  in  32  from memory.

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE: `req_ready`=1. When `req_valid`&`req_ready` at an edge, the unit latches all `req_*` fields, loads the wait counter with `MEM_LATENCY-1`, and moves to ACCESS.
- ACCESS: `memRead`=!write or `memWrite`=write. `address`, `byteOperations`, and `write_data` are held constant. The counter decrements each cycle; at count 0 the unit captures `read_data` (loads only) and moves to DONE.
- DONE: `rsp_valid`=1 for exactly one cycle, then the FSM returns to IDLE.
- Byte store: `write_data` = {24'b0, req_wdata[7:0]}.
- Word store: `write_data` = req_wdata.
- Byte load: `rsp_data` = {{24{req_signed & read_data[7]}}, read_data[7:0]}.
- Word load: `rsp_data` = read_data.
- `memRead` and `memWrite` are never high together. Both are 0 outside ACCESS.
- All memory-side outputs and `rsp_*` are registered.
- `req_ready` = (state==IDLE) & !reset.

## Timing
- Reset values:
  - state IDLE.
  - `memRead`, `memWrite`, `byteOperations` = 0.
  - `address` = 0, `write_data` = 0.
  - `rsp_valid` = 0, `rsp_data` = 0, `rsp_error` = 0.
- Accept at edge T: strobes are high during cycles T+1 .. T+MEM_LATENCY; `rsp_valid` is high in cycle T+MEM_LATENCY+1; `req_ready` returns in cycle T+MEM_LATENCY+2.
- Throughput: one request per MEM_LATENCY+2 cycles.
- Load data is sampled at the last ACCESS edge. `read_data` must be valid by then.
- A request presented while `req_ready`=0 is ignored and not queued. The requester holds `req_valid` until it is accepted.
- Reset asserted mid-ACCESS or in DONE aborts the access: strobes drop at that edge and no `rsp_valid` is issued.
- `req_*` changing after acceptance has no effect on the access in flight.

## Configuration
- `MEM_ALIGN_CHECK_EN` defined: a word request with `req_addr[1:0]`≠0 is accepted but no strobes are issued. The FSM goes IDLE→DONE; `rsp_valid` is high in cycle T+1 with `rsp_error`=1 and `rsp_data`=0. Byte requests are never flagged.
- `MEM_ALIGN_CHECK_EN` undefined: no alignment check. `rsp_error` is tied to 0 and every request performs the normal access with the address passed unchanged.

## Test plan
- Reset, then idle: all outputs at their reset values, and `req_ready`=1 in the first cycle after `reset` drops.
- Word store, addr 18'h0000C, wdata 32'h00000001, MEM_LATENCY=1: `memWrite`=1 and `byteOperations`=0 for exactly 1 cycle with `address`=18'h0000C; `rsp_valid` pulses with `rsp_data`=0.
- Byte load, addr 18'h0000F, memory returns 32'hXXXXXX80:
  - `req_signed`=1 → `rsp_data`=32'hFFFFFF80.
  - `req_signed`=0 → `rsp_data`=32'h00000080.
- MEM_LATENCY=3 word load returning 32'hDEADBEEF: `memRead` high for exactly 3 cycles, `rsp_valid` 4 cycles after acceptance, `rsp_data`=32'hDEADBEEF. A second `req_valid` held during the access is accepted only once `req_ready` returns.
- Reset asserted in the 2nd ACCESS cycle of a store: strobes are 0 from the next cycle and no `rsp_valid` is ever issued.
- With `MEM_ALIGN_CHECK_EN`, word load at addr 18'h00002: no `memRead` pulse, `rsp_valid`=1 and `rsp_error`=1 one cycle after acceptance. Without the macro, the same load issues a normal `memRead` and `rsp_error`=0.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit
//   Initiator-side controller for memory_block. Accepts one load/store at a
//   time over a valid/ready handshake, holds the memory strobes for
//   MEM_LATENCY cycles, then returns a one-cycle response. Byte loads are
//   sign- or zero-extended; byte stores place the byte in write_data[7:0].
//
//   Optional feature macro: MEM_ALIGN_CHECK_EN
//     defined   : word requests with addr[1:0]!=0 skip the access and respond
//                 on the next cycle with rsp_error=1, rsp_data=0.
//     undefined : no alignment check, rsp_error is always 0.
//
//   Ports
//     clk, reset                    clock, synchronous active-high reset
//     req_valid/req_ready           request handshake
//     req_write/byte/signed         store, byte-access, byte-load sign-extend
//     req_addr, req_wdata           byte address, store data
//     rsp_valid/rsp_data/rsp_error  one-cycle response
//     address, write_data,
//     byteOperations, memRead,
//     memWrite                      registered memory-side strobes
//     read_data                     memory read data
module mem_access_unit #(
    parameter int MEM_LATENCY = 1,
    parameter int ADDR_W      = 18
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic              req_byte,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_data,
    output logic              rsp_error,
    output logic [ADDR_W-1:0] address,
    output logic [31:0]       write_data,
    output logic              byteOperations,
    output logic              memRead,
    output logic              memWrite,
    input  logic [31:0]       read_data
);

    localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             r_write, r_byte, r_signed;
    logic             w_accept, w_misalign;
    logic             w_rd_nxt, w_wr_nxt;
    logic             w_rsp_valid_nxt, w_rsp_error_nxt;
    logic [31:0]      w_rsp_data_nxt, w_ext;

    assign req_ready = (r_state == S_IDLE) & ~reset;
    assign w_accept  = req_valid & req_ready;

`ifdef MEM_ALIGN_CHECK_EN
    // Byte accesses may target any byte lane; only word accesses are checked.
    assign w_misalign = ~req_byte & (req_addr[1:0] != 2'b00);
`else
    assign w_misalign = 1'b0;
`endif

    // Load result formatting uses the fields latched at acceptance.
    assign w_ext = r_byte ? {{24{r_signed & read_data[7]}}, read_data[7:0]}
                          : read_data;

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_rd_nxt        = 1'b0;
        w_wr_nxt        = 1'b0;
        w_rsp_valid_nxt = 1'b0;
        w_rsp_error_nxt = 1'b0;
        w_rsp_data_nxt  = '0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_cnt_nxt = CNT_W'(MEM_LATENCY - 1);
                    if (w_misalign) begin
                        // Rejected access: respond next cycle, no strobes.
                        w_state_nxt     = S_DONE;
                        w_rsp_valid_nxt = 1'b1;
                        w_rsp_error_nxt = 1'b1;
                    end else begin
                        w_state_nxt = S_ACCESS;
                        w_rd_nxt    = ~req_write;
                        w_wr_nxt    = req_write;
                    end
                end
            end
            S_ACCESS: begin
                if (r_cnt == '0) begin
                    // Last access edge: read_data is sampled here.
                    w_state_nxt     = S_DONE;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_data_nxt  = r_write ? 32'h0 : w_ext;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                    w_rd_nxt  = ~r_write;
                    w_wr_nxt  = r_write;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_write        <= 1'b0;
            r_byte         <= 1'b0;
            r_signed       <= 1'b0;
            address        <= '0;
            write_data     <= '0;
            byteOperations <= 1'b0;
            memRead        <= 1'b0;
            memWrite       <= 1'b0;
            rsp_valid      <= 1'b0;
            rsp_data       <= '0;
            rsp_error      <= 1'b0;
        end else begin
            memRead   <= w_rd_nxt;
            memWrite  <= w_wr_nxt;
            rsp_valid <= w_rsp_valid_nxt;
            rsp_data  <= w_rsp_data_nxt;
            rsp_error <= w_rsp_error_nxt;
            // Memory-side fields only change at acceptance, so they stay
            // stable for the whole access regardless of req_* activity.
            if (w_accept) begin
                r_write        <= req_write;
                r_byte         <= req_byte;
                r_signed       <= req_signed;
                address        <= req_addr;
                byteOperations <= req_byte;
                write_data     <= ~req_write ? 32'h0 :
                                  req_byte   ? {24'h0, req_wdata[7:0]} : req_wdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

    localparam int AW = 18;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid, req_write, req_byte, req_signed;
    logic [AW-1:0] req_addr;
    logic [31:0]   req_wdata, read_data;

    logic          rdy1, rv1, er1, bo1, mr1, mw1;
    logic [31:0]   rd1, wd1;
    logic [AW-1:0] ad1;
    logic          rdy3, rv3, er3, bo3, mr3, mw3;
    logic [31:0]   rd3, wd3;
    logic [AW-1:0] ad3;

    always #5 clk = ~clk;

    mem_access_unit #(.MEM_LATENCY(1), .ADDR_W(AW)) u_dut1 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(rdy1),
        .req_write(req_write), .req_byte(req_byte), .req_signed(req_signed),
        .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rv1),
        .rsp_data(rd1), .rsp_error(er1), .address(ad1), .write_data(wd1),
        .byteOperations(bo1), .memRead(mr1), .memWrite(mw1), .read_data(read_data)
    );

    mem_access_unit #(.MEM_LATENCY(3), .ADDR_W(AW)) u_dut3 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(rdy3),
        .req_write(req_write), .req_byte(req_byte), .req_signed(req_signed),
        .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rv3),
        .rsp_data(rd3), .rsp_error(er3), .address(ad3), .write_data(wd3),
        .byteOperations(bo3), .memRead(mr3), .memWrite(mw3), .read_data(read_data)
    );

    // sel=0 observes the latency-1 instance, sel=1 the latency-3 instance.
    logic          sel;
    logic          s_rdy, s_rv, s_er, s_bo, s_mr, s_mw;
    logic [31:0]   s_rd, s_wd;
    logic [AW-1:0] s_ad;
    assign s_rdy = sel ? rdy3 : rdy1;
    assign s_rv  = sel ? rv3  : rv1;
    assign s_er  = sel ? er3  : er1;
    assign s_bo  = sel ? bo3  : bo1;
    assign s_mr  = sel ? mr3  : mr1;
    assign s_mw  = sel ? mw3  : mw1;
    assign s_rd  = sel ? rd3  : rd1;
    assign s_wd  = sel ? wd3  : wd1;
    assign s_ad  = sel ? ad3  : ad1;

    typedef struct {
        logic          sel;
        logic          wr, bt, sg;
        logic [AW-1:0] addr;
        logic [31:0]   wdata, rdata, exp_data;
        logic          exp_err;
        int            exp_strb;
    } vec_t;

    vec_t vecs[9];
    int   n_chk = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_ready(input string name);
        logic got;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (s_rdy) begin
                got = 1'b1;
                break;
            end
        end
        chk({name, "_ready_timeout"}, {31'h0, got}, 32'h1);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int          lat, strb, first, rsp_cyc, nrsp, rdy_cyc, both, bad;
        logic [31:0] rsp_d, exp_wd;
        logic        rsp_e;
        string       nm;
        nm     = $sformatf("vec%0d", idx);
        lat    = v.sel ? 3 : 1;
        exp_wd = v.bt ? {24'h0, v.wdata[7:0]} : v.wdata;
        sel = v.sel; req_write = v.wr; req_byte = v.bt; req_signed = v.sg;
        req_addr = v.addr; req_wdata = v.wdata; req_valid = 1'b1;
        wait_ready(nm);
        @(posedge clk); #1;
        // Scramble request fields after acceptance; the access must not notice.
        req_valid = 1'b0; req_write = ~v.wr; req_byte = ~v.bt; req_signed = ~v.sg;
        req_addr = ~v.addr; req_wdata = ~v.wdata; read_data = v.rdata;
        strb = 0; first = -1; rsp_cyc = -1; nrsp = 0; rdy_cyc = -1; both = 0; bad = 0;
        rsp_d = 32'h0; rsp_e = 1'b0;
        for (int k = 1; k <= lat + 3; k++) begin
            @(negedge clk);
            if (s_mr && s_mw) both++;
            if (s_mr || s_mw) begin
                strb++;
                if (first < 0) first = k;
                if (s_ad !== v.addr || s_bo !== v.bt || s_mw !== v.wr ||
                    (v.wr && s_wd !== exp_wd)) bad++;
            end
            if (s_rv) begin
                nrsp++; rsp_cyc = k; rsp_d = s_rd; rsp_e = s_er;
            end
            if (s_rdy && rdy_cyc < 0) rdy_cyc = k;
        end
        chk({nm, "_strobe_cycles"}, strb, v.exp_strb);
        chk({nm, "_rd_wr_overlap"}, both, 0);
        chk({nm, "_mem_fields"}, bad, 0);
        if (v.exp_strb > 0) chk({nm, "_strobe_start"}, first, 1);
        chk({nm, "_rsp_count"}, nrsp, 1);
        chk({nm, "_rsp_cycle"}, rsp_cyc, v.exp_strb + 1);
        chk({nm, "_rsp_data"}, rsp_d, v.exp_data);
        chk({nm, "_rsp_error"}, {31'h0, rsp_e}, {31'h0, v.exp_err});
        chk({nm, "_ready_return"}, rdy_cyc, v.exp_strb + 2);
    endtask

    initial begin
        int first_rdy, strb, rsp_cyc, nrv;
        logic [31:0] rsp_d;

        //            sel   wr    bt    sg    addr       wdata         rdata         exp_data      err  strb
        vecs[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 18'h0000C, 32'h00000001, 32'h0,        32'h00000000, 1'b0, 1};
        vecs[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 18'h0000F, 32'h0,        32'h12345680, 32'hFFFFFF80, 1'b0, 1};
        vecs[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 18'h0000F, 32'h0,        32'hABCDEF80, 32'h00000080, 1'b0, 1};
        vecs[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 18'h00010, 32'h0,        32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 3};
        vecs[4] = '{1'b0, 1'b1, 1'b1, 1'b0, 18'h00003, 32'hA5A5A5C3, 32'h0,        32'h00000000, 1'b0, 1};
        vecs[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 18'h00021, 32'h0,        32'hFFFFFF7F, 32'h0000007F, 1'b0, 3};
`ifdef MEM_ALIGN_CHECK_EN
        vecs[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 18'h00002, 32'h0,        32'hCAFEF00D, 32'h00000000, 1'b1, 0};
`else
        vecs[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 18'h00002, 32'h0,        32'hCAFEF00D, 32'hCAFEF00D, 1'b0, 1};
`endif
        vecs[7] = '{1'b1, 1'b1, 1'b0, 1'b0, 18'h3FFFC, 32'h89ABCDEF, 32'h0,        32'h00000000, 1'b0, 3};
        vecs[8] = '{1'b0, 1'b0, 1'b1, 1'b1, 18'h00001, 32'h0,        32'h000000FF, 32'hFFFFFFFF, 1'b0, 1};

        sel = 1'b0; reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_byte = 1'b0;
        req_signed = 1'b0; req_addr = '0; req_wdata = '0; read_data = '0;

        // Reset and idle state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("ready_in_reset", {30'h0, rdy1, rdy3}, 32'h0);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", {30'h0, rdy1, rdy3}, 32'h3);
        chk("strobes_reset1", {27'h0, mr1, mw1, bo1, rv1, er1}, 32'h0);
        chk("strobes_reset3", {27'h0, mr3, mw3, bo3, rv3, er3}, 32'h0);
        chk("addr_reset", {14'h0, ad1 | ad3}, 32'h0);
        chk("wdata_reset", wd1 | wd3, 32'h0);
        chk("rdata_reset", rd1 | rd3, 32'h0);

        for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

        // Back-to-back on latency 3: second request held valid throughout.
        sel = 1'b1; req_write = 1'b0; req_byte = 1'b0; req_signed = 1'b0;
        req_addr = 18'h00040; read_data = 32'h01234567; req_valid = 1'b1;
        wait_ready("b2b");
        @(posedge clk); #1;
        first_rdy = -1; strb = 0; rsp_cyc = -1; rsp_d = 32'h0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (s_mr) strb++;
            if (s_rv) begin rsp_cyc = k; rsp_d = s_rd; end
            if (s_rdy && first_rdy < 0) first_rdy = k;
        end
        chk("b2b_strobes", strb, 3);
        chk("b2b_rsp_cycle", rsp_cyc, 4);
        chk("b2b_rsp_data", rsp_d, 32'h01234567);
        chk("b2b_ready_return", first_rdy, 5);
        @(posedge clk); #1 req_valid = 1'b0;
        @(negedge clk);
        chk("b2b_second_accept", {31'h0, s_mr}, 32'h1);
        repeat (6) @(negedge clk);

        // Reset during the 2nd access cycle of a latency-3 store.
        sel = 1'b1; req_write = 1'b1; req_byte = 1'b0; req_addr = 18'h00100;
        req_wdata = 32'h55AA55AA; req_valid = 1'b1;
        wait_ready("abort");
        @(posedge clk); #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("abort_strobe_before", {31'h0, s_mw}, 32'h1);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_strobe_after", {30'h0, s_mw, s_mr}, 32'h0);
        @(posedge clk); #1 reset = 1'b0;
        nrv = 0;
        @(negedge clk);
        chk("abort_ready", {31'h0, s_rdy}, 32'h1);
        for (int k = 0; k < 6; k++) begin
            if (s_rv) nrv++;
            @(negedge clk);
        end
        chk("abort_no_rsp", nrv, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule
